// File: rtl/jpeg_qseq_pkg.sv
// Shared types and constants for the jpeg_qseq quantisation sequencer.
// Optional build macro used by the design: JPEG_QSEQ_SAT_EN.
package jpeg_qseq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, QUANT, FLUSH} state_e;

  localparam int OW     = 16;
  localparam int STAGES = 2;

  // Half-LSB of the fixed-point product, added before the arithmetic shift.
  function automatic logic [63:0] rnd_const(input int unsigned sh);
    return (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
  endfunction

endpackage

// File: rtl/jpeg_qseq_lane.sv
// One multiply/round/saturate lane with a registered 16-bit result.
// JPEG_QSEQ_SAT_EN selects clamping (and a saturation flag) instead of wrap.
module jpeg_qseq_lane
  import jpeg_qseq_pkg::*;
#(
  parameter int CW = 16,
  parameter int RW = 17,
  parameter int SH = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic [CW-1:0] x_i,
  input  logic [RW-1:0] rec_i,
  output logic [OW-1:0] res_o,
  output logic          sat_o
);

  localparam int PW = CW + RW + 1;
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(SH));

  logic signed [PW-1:0] xs, rs, prod, rnd;
  logic        [OW-1:0] res_d, res_q;
  logic                 hi_same;

  assign xs   = PW'($signed(x_i));
  assign rs   = PW'(rec_i);
  assign prod = xs * rs;
  assign rnd  = (prod + RND) >>> SH;

  // Result fits in OW bits only when every bit above the sign is a copy of it.
  assign hi_same = (&rnd[PW-1:OW-1]) | ~(|rnd[PW-1:OW-1]);

`ifdef JPEG_QSEQ_SAT_EN
  assign sat_o = ~hi_same;
  always_comb begin
    res_d = rnd[OW-1:0];
    if (!hi_same) res_d = rnd[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = hi_same;
  assign sat_o     = 1'b0;
  assign res_d     = rnd[OW-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)      res_q <= '0;
    else if (vld_i) res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/jpeg_qseq.sv
// Quantisation sequencer: row-at-a-time DCT coefficients -> packed 16-bit pairs.
// Build macro JPEG_QSEQ_SAT_EN enables clamping and the sticky ovf_o flag.
module jpeg_qseq
  import jpeg_qseq_pkg::*;
#(
  parameter int N    = 8,
  parameter int CW   = 16,
  parameter int RW   = 17,
  parameter int SH   = 16,
  parameter int NTAB = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [$clog2(NTAB)-1:0]  tab_sel_i,
  input  logic                     row_valid_i,
  output logic                     row_ready_o,
  input  logic [N*CW-1:0]          row_i,
  input  logic                     rec_we_i,
  input  logic [$clog2(NTAB)-1:0]  rec_tab_i,
  input  logic [$clog2(N*N)-1:0]   rec_addr_i,
  input  logic [RW-1:0]            rec_dat_i,
  output logic                     wr_en_o,
  output logic [$clog2(N*N/2)-1:0] wr_addr_o,
  output logic [31:0]              wr_dat_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o
);

  localparam int HN    = N / 2;
  localparam int NW    = N * N / 2;
  localparam int TW    = $clog2(NTAB);
  localparam int WAW   = $clog2(NW);
  localparam int RCW   = $clog2(N);
  localparam int KW    = (HN > 1) ? $clog2(HN) : 1;
  localparam int DEPTH = NTAB * NW;
  localparam int RAW   = $clog2(DEPTH);
  localparam logic [KW-1:0]  LAST_K = KW'(HN - 1);
  localparam logic [RCW-1:0] LAST_R = RCW'(N - 1);

  state_e                       state_q;
  logic [TW-1:0]                tab_q;
  logic [RCW-1:0]               row_q;
  logic [KW-1:0]                k_q;
  logic [HN-1:0][1:0][CW-1:0]   coef_q;
  logic                         flush_q, done_q;
  logic                         issue;

  assign issue       = (state_q == QUANT);
  assign row_ready_o = (state_q == LOAD);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tab_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= LOAD;
          tab_q   <= tab_sel_i;
          row_q   <= '0;
          k_q     <= '0;
        end
        LOAD: if (row_valid_i) begin
          coef_q  <= row_i;
          k_q     <= '0;
          state_q <= QUANT;
        end
        QUANT: begin
          if (k_q == LAST_K) begin
            k_q <= '0;
            if (row_q == LAST_R) begin
              state_q <= FLUSH;
              flush_q <= 1'b0;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= LOAD;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        FLUSH: begin
          // Two cycles here let the last pair leave the read and lane stages.
          if (flush_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            flush_q <= 1'b1;
          end
        end
      endcase
    end
  end

  logic [WAW-1:0] waddr;
  logic [RAW-1:0] rd_idx, wr_idx;

  assign waddr  = WAW'(int'(row_q) * HN + int'(k_q));
  assign rd_idx = RAW'(int'(tab_q) * NW + int'(waddr));
  assign wr_idx = RAW'(int'(rec_tab_i) * NW + int'(rec_addr_i >> 1));

  // Even and odd columns live in separate banks so a pair reads in one cycle.
  logic [RW-1:0]          bank_q [2][DEPTH];
  logic [1:0][RW-1:0]     rec_q;

  always_ff @(posedge clk_i) begin
    if (rec_we_i && !busy_o) bank_q[rec_addr_i[0]][wr_idx] <= rec_dat_i;
    for (int l = 0; l < 2; l++) rec_q[l] <= bank_q[l][rd_idx];
  end

  logic [STAGES:1]        vld_pipe_q;
  logic [1:0][CW-1:0]     x_q;
  logic [WAW-1:0]         addr1_q, addr2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      x_q        <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], issue};
      if (issue) begin
        x_q     <= coef_q[k_q];
        addr1_q <= waddr;
      end
      if (vld_pipe_q[1]) addr2_q <= addr1_q;
    end
  end

  logic [1:0][OW-1:0] res;
  logic [1:0]         sat;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    jpeg_qseq_lane #(.CW(CW), .RW(RW), .SH(SH)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .vld_i (vld_pipe_q[1]),
      .x_i   (x_q[l]),
      .rec_i (rec_q[l]),
      .res_o (res[l]),
      .sat_o (sat[l])
    );
  end

  assign wr_en_o   = vld_pipe_q[STAGES];
  assign wr_addr_o = addr2_q;
  assign wr_dat_o  = res;

`ifdef JPEG_QSEQ_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                           ovf_q <= 1'b0;
    else if (state_q == IDLE && start_i) ovf_q <= 1'b0;
    else if (vld_pipe_q[1] && |sat)      ovf_q <= 1'b1;
  end
  assign ovf_o = ovf_q;
`else
  logic unused_sat;
  assign unused_sat = |sat;
  assign ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_qseq.sv
// Scoreboard bench for jpeg_qseq; honours JPEG_QSEQ_SAT_EN in its model.
module tb_jpeg_qseq;
  localparam int N = 8, CW = 16, RW = 17, SH = 16, NTAB = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 1'b0, row_valid_i = 1'b0, rec_we_i = 1'b0;
  logic [0:0] tab_sel_i = '0, rec_tab_i = '0;
  logic [N*CW-1:0] row_i = '0;
  logic [5:0] rec_addr_i = '0;
  logic [RW-1:0] rec_dat_i = '0;
  logic row_ready_o, wr_en_o, busy_o, done_o, ovf_o;
  logic [4:0] wr_addr_o;
  logic [31:0] wr_dat_o;

  jpeg_qseq #(.N(N), .CW(CW), .RW(RW), .SH(SH), .NTAB(NTAB)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .tab_sel_i(tab_sel_i),
    .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .row_i(row_i),
    .rec_we_i(rec_we_i), .rec_tab_i(rec_tab_i), .rec_addr_i(rec_addr_i),
    .rec_dat_i(rec_dat_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_dat_o(wr_dat_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t sb[$];
  logic [16:0] mrec [2][64];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int done_cnt = 0, done_cyc = 0, acc_cyc = -100, cur_tab = 0;
  bit exp_ovf = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] qm(input logic signed [15:0] x, input logic [16:0] rec);
    longint p, r;
    logic s;
    p = longint'(x) * longint'(rec);
    r = (p + 64'sd32768) >>> 16;
    s = 1'b0;
`ifdef JPEG_QSEQ_SAT_EN
    if (r > 32767) begin r = 32767; s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
`endif
    return {s, r[15:0]};
  endfunction

  // Output monitor: scoreboard pop, done tracking, ready must stay low during QUANT.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_o) begin
        if (sb.size() == 0) chk("wr_unexpected", 64'(sb.size()), 64'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", 64'(wr_addr_o), 64'(e.a));
          chk("wr_dat", 64'(wr_dat_o), 64'(e.d));
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy_o), 64'd0);
      end
      if (cyc > acc_cyc && cyc <= acc_cyc + N/2) chk("ready_in_quant", 64'(row_ready_o), 64'd0);
    end
  end

  task automatic fill_tab(input int tab, input logic [16:0] v);
    for (int a = 0; a < N*N; a++) begin
      @(negedge clk);
      rec_we_i = 1'b1; rec_tab_i = tab[0]; rec_addr_i = 6'(a); rec_dat_i = v;
      mrec[tab][a] = v;
    end
    @(negedge clk);
    rec_we_i = 1'b0;
  endtask

  task automatic send_row(input logic [N*CW-1:0] d, input int r, input bit rnd);
    bit acc;
    int g;
    logic [16:0] lo, hi;
    acc = 1'b0; g = 0;
    row_i = d;
    while (!acc) begin
      @(negedge clk);
      row_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        rec_we_i = 1'($urandom_range(0, 1)); rec_tab_i = 1'($urandom_range(0, 1));
        rec_addr_i = 6'($urandom); rec_dat_i = 17'($urandom);
      end
      if (row_valid_i && row_ready_o) begin
        acc = 1'b1;
        acc_cyc = cyc;
        for (int k = 0; k < N/2; k++) begin
          lo = qm(d[(2*k)*CW +: CW], mrec[cur_tab][r*N + 2*k]);
          hi = qm(d[(2*k+1)*CW +: CW], mrec[cur_tab][r*N + 2*k + 1]);
          if (lo[16] || hi[16]) exp_ovf = 1'b1;
          sb.push_back('{a: 5'(r*(N/2) + k), d: {hi[15:0], lo[15:0]}});
        end
      end else if (++g > 200) begin
        chk("row_timeout", 64'(g), 64'd200);
        row_valid_i = 1'b0; rec_we_i = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    row_valid_i = 1'b0; rec_we_i = 1'b0;
  endtask

  // mode 0: +100/-100 alternating, 1: constant val, 2: random coefficients
  task automatic run_block(input int tab, input int mode, input int val, input bit rnd,
                           input int nrows, input bit chk_lat);
    logic [N*CW-1:0] d;
    logic [15:0] x;
    int scyc, d0, g;
    @(negedge clk);
    start_i = 1'b1; tab_sel_i = tab[0];
    scyc = cyc; d0 = done_cnt; cur_tab = tab; exp_ovf = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      for (int j = 0; j < N; j++) begin
        if (mode == 0) x = (j % 2) ? -16'sd100 : 16'sd100;
        else if (mode == 1) x = val[15:0];
        else x = 16'($urandom);
        d[j*CW +: CW] = x;
      end
      send_row(d, r, rnd);
    end
    if (nrows == N) begin
      g = 0;
      while (done_cnt == d0 && g < 100) begin @(negedge clk); g++; end
      repeat (3) @(negedge clk);
      chk("done_once", 64'(done_cnt - d0), 64'd1);
      if (chk_lat) chk("latency", 64'(done_cyc - scyc), 64'(N*(N/2 + 1) + 3));
      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("ovf", 64'(ovf_o), 64'(exp_ovf));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(row_ready_o), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
    chk({tag, "_wr_dat"}, 64'(wr_dat_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_o), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    fill_tab(0, 17'd2048);
    fill_tab(1, 17'd4096);
    run_block(0, 0, 0, 1'b0, N, 1'b1);       // rounding: every word 0xFFFD0003
    run_block(1, 1, 48, 1'b0, N, 1'b1);      // table 1: 48/16 = 3
    run_block(0, 1, 48, 1'b0, N, 1'b1);      // table 0 untouched: 48/32 -> 2
    run_block(0, 2, 0, 1'b1, N, 1'b0);       // random valid, writes while busy
    fill_tab(0, 17'h1FFFF);
    run_block(0, 1, 32767, 1'b0, N, 1'b1);   // saturation / wrap
    repeat (4) @(negedge clk);
    chk("ovf_sticky", 64'(ovf_o), 64'(exp_ovf));

    run_block(1, 2, 0, 1'b0, 4, 1'b0);       // abort after row 3
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    acc_cyc = -100;
    @(negedge clk);
    chk_zero("midrst");
    run_block(1, 2, 0, 1'b0, N, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
